// File: rtl/fetch_unit.sv
// MIPS IF stage plus IF/ID register: PC, imem request, and redirect from M-branch and D-jump.
// One cycle from imem_ready to IF/ID. stall_f/imem_ready=0 hold the PC; stall_d holds IF/ID; redirects override both.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             stall_f,
  input  logic             stall_d,
  input  logic             flush_d,
  input  logic             pcsrc_m,
  input  logic [31:0]      pcbranch_m,
  input  logic             jump_d,
  output logic [31:0]      imem_addr,
  output logic             imem_req,
  input  logic [31:0]      imem_rdata,
  input  logic             imem_ready,
  output logic [31:0]      instr_d,
  output logic [5:0]       op_d,
  output logic [5:0]       funct_d,
  output logic [31:0]      pcplus4_d,
  output logic             valid_d,
  output logic [CNT_W-1:0] fetch_count
);

  logic [31:0] pc;
  logic [31:0] pcplus4_f;
  logic [31:0] jta;
  logic        run;
  logic        jump_eff;
  logic        fetch_ok;
  logic        squash_d;

  assign pcplus4_f = pc + 32'd4;
  assign jta       = {pcplus4_d[31:28], instr_d[25:0], 2'b00};
  assign jump_eff  = jump_d & valid_d & ~stall_d;
  assign fetch_ok  = run & ~stall_f & imem_ready;
  assign squash_d  = flush_d | pcsrc_m | jump_eff;

  assign imem_addr = pc;
  assign imem_req  = run & ~stall_f;
  assign op_d      = instr_d[31:26];
  assign funct_d   = instr_d[5:0];

  // run rises on the first edge after reset release, so no request straddles the release
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) run <= 1'b0;
    else          run <= 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      pc <= {RESET_PC[31:2], 2'b00};
    else if (pcsrc_m)  pc <= {pcbranch_m[31:2], 2'b00};
    else if (jump_eff) pc <= jta;
    else if (fetch_ok) pc <= pcplus4_f;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr_d     <= 32'd0;
      pcplus4_d   <= 32'd0;
      valid_d     <= 1'b0;
      fetch_count <= '0;
    end else if (squash_d) begin
      instr_d   <= 32'd0;
      pcplus4_d <= 32'd0;
      valid_d   <= 1'b0;
    end else if (!stall_d) begin
      if (fetch_ok) begin
        instr_d     <= imem_rdata;
        pcplus4_d   <= pcplus4_f;
        valid_d     <= 1'b1;
        fetch_count <= fetch_count + CNT_W'(1);
      end else begin
        // memory not answering or F stalled: D sees a bubble rather than a repeat
        instr_d   <= 32'd0;
        pcplus4_d <= 32'd0;
        valid_d   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run against a cycle-level reference model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall_f, stall_d, flush_d, pcsrc_m, jump_d, imem_ready;
  logic [31:0] pcbranch_m;
  logic [31:0] imem_addr, imem_rdata, instr_d, pcplus4_d;
  logic        imem_req, valid_d;
  logic [5:0]  op_d, funct_d;
  logic [31:0] fetch_count;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [31:0] m_pc, m_instr, m_pp4, m_cnt;
  logic        m_valid, m_run;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h10)      return 32'h0800_0040;
    else if (a == 32'h20) return 32'h0800_0100;
    else                  return a + 32'h100;
  endfunction

  assign imem_rdata = mem(imem_addr);

  fetch_unit dut (
    .clk(clk), .reset_n(reset_n), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .pcsrc_m(pcsrc_m), .pcbranch_m(pcbranch_m), .jump_d(jump_d),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .instr_d(instr_d), .op_d(op_d), .funct_d(funct_d), .pcplus4_d(pcplus4_d),
    .valid_d(valid_d), .fetch_count(fetch_count)
  );

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pp4 = 32'h0; m_cnt = 32'h0; m_valid = 1'b0; m_run = 1'b0;
  endtask

  task automatic idle_inputs();
    stall_f = 0; stall_d = 0; flush_d = 0; pcsrc_m = 0; jump_d = 0; pcbranch_m = 32'h0; imem_ready = 0;
  endtask

  // advance one clock; the model applies the fetch rules to the inputs seen before the edge
  task automatic step();
    logic [31:0] n_pc, n_instr, n_pp4, n_cnt;
    logic        n_valid, taken_jump, got_word;
    taken_jump = jump_d && m_valid && !stall_d;
    got_word   = m_run && !stall_f && imem_ready;
    n_instr = m_instr; n_pp4 = m_pp4; n_valid = m_valid; n_cnt = m_cnt;
    if (pcsrc_m)         n_pc = pcbranch_m;
    else if (taken_jump) n_pc = {m_pp4[31:28], m_instr[25:0], 2'b00};
    else if (got_word)   n_pc = m_pc + 32'd4;
    else                 n_pc = m_pc;
    if (flush_d || pcsrc_m || taken_jump) begin
      n_instr = 0; n_pp4 = 0; n_valid = 0;
    end else if (!stall_d) begin
      if (got_word) begin
        n_instr = mem(m_pc); n_pp4 = m_pc + 32'd4; n_valid = 1; n_cnt = m_cnt + 1;
      end else begin
        n_instr = 0; n_pp4 = 0; n_valid = 0;
      end
    end
    @(posedge clk);
    m_pc = n_pc; m_instr = n_instr; m_pp4 = n_pp4; m_valid = n_valid; m_cnt = n_cnt; m_run = 1'b1;
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    #2 reset_n = 0;
    model_reset();
    #3 reset_n = 1;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want %h", imem_addr, 32'h0); end
    checks++; if (instr_d !== 32'h0 || pcplus4_d !== 32'h0) begin errors++; $display("FAIL reset_ifid got %h/%h want 0/0", instr_d, pcplus4_d); end
    checks++; if (valid_d !== 1'b0 || fetch_count !== 32'h0) begin errors++; $display("FAIL reset_valid_cnt got %b/%0d want 0/0", valid_d, fetch_count); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", imem_req); end
    #2 reset_n = 1;
    step();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL req_after_release got %b want 1", imem_req); end
  endtask

  task automatic test_seq();
    do_reset();
    imem_ready = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (instr_d !== 32'h100 + 32'(4*i) || pcplus4_d !== 32'(4*(i+1)) || valid_d !== 1'b1) begin
        errors++; $display("FAIL seq_%0d got instr %h pc4 %h v %b want %h %h 1", i, instr_d, pcplus4_d, valid_d, 32'h100 + 32'(4*i), 32'(4*(i+1)));
      end
    end
    checks++; if (fetch_count !== 32'd3) begin errors++; $display("FAIL seq_count got %0d want 3", fetch_count); end
  endtask

  task automatic test_wait();
    do_reset();
    imem_ready = 1;
    for (int i = 0; i < 10 && imem_addr !== 32'h8; i++) step();
    checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL wait_reach got %h want 8", imem_addr); end
    imem_ready = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (imem_addr !== 32'h8 || valid_d !== 1'b0 || fetch_count !== 32'd2) begin
        errors++; $display("FAIL wait_hold_%0d got pc %h v %b cnt %0d want 8 0 2", i, imem_addr, valid_d, fetch_count);
      end
    end
    imem_ready = 1;
    step();
    checks++; if (instr_d !== 32'h108 || pcplus4_d !== 32'hC || valid_d !== 1'b1 || fetch_count !== 32'd3) begin
      errors++; $display("FAIL wait_deliver got %h %h %b %0d want 108 c 1 3", instr_d, pcplus4_d, valid_d, fetch_count); end
    imem_ready = 0;
    step();
    checks++; if (valid_d !== 1'b0) begin errors++; $display("FAIL wait_once got v %b want 0", valid_d); end
  endtask

  task automatic run_to_jump(input logic [31:0] pp4);
    imem_ready = 1;
    for (int i = 0; i < 20 && !(pcplus4_d === pp4 && valid_d === 1'b1); i++) step();
    checks++; if (pcplus4_d !== pp4 || valid_d !== 1'b1) begin errors++; $display("FAIL reach_pc4 got %h want %h", pcplus4_d, pp4); end
  endtask

  task automatic test_jump();
    do_reset();
    run_to_jump(32'h14);
    checks++; if (instr_d !== 32'h0800_0040 || op_d !== 6'h02) begin errors++; $display("FAIL jump_instr got %h op %h want 08000040 02", instr_d, op_d); end
    jump_d = 1;
    step();
    jump_d = 0;
    checks++; if (imem_addr !== 32'h100 || valid_d !== 1'b0 || instr_d !== 32'h0) begin
      errors++; $display("FAIL jump_redirect got pc %h v %b instr %h want 100 0 0", imem_addr, valid_d, instr_d); end
    step();
    checks++; if (instr_d !== 32'h200 || pcplus4_d !== 32'h104 || valid_d !== 1'b1) begin
      errors++; $display("FAIL jump_target got %h %h %b want 200 104 1", instr_d, pcplus4_d, valid_d); end
    do_reset();
    run_to_jump(32'h14);
    jump_d = 1; stall_d = 1;
    step();
    jump_d = 0; stall_d = 0;
    checks++; if (imem_addr !== 32'h18 || instr_d !== 32'h0800_0040 || pcplus4_d !== 32'h14 || valid_d !== 1'b1) begin
      errors++; $display("FAIL jump_stalled got pc %h instr %h pc4 %h v %b want 18 08000040 14 1", imem_addr, instr_d, pcplus4_d, valid_d); end
  endtask

  task automatic test_branch();
    do_reset();
    imem_ready = 1;
    repeat (3) step();
    stall_f = 1; imem_ready = 0; pcsrc_m = 1; pcbranch_m = 32'h200;
    step();
    checks++; if (imem_addr !== 32'h200 || instr_d !== 32'h0 || valid_d !== 1'b0) begin
      errors++; $display("FAIL branch got pc %h instr %h v %b want 200 0 0", imem_addr, instr_d, valid_d); end
    idle_inputs();
    do_reset();
    run_to_jump(32'h24);
    pcsrc_m = 1; pcbranch_m = 32'h300; jump_d = 1;
    step();
    idle_inputs();
    checks++; if (imem_addr !== 32'h300 || valid_d !== 1'b0) begin
      errors++; $display("FAIL branch_vs_jump got pc %h v %b want 300 0", imem_addr, valid_d); end
  endtask

  task automatic test_priority_wrap_reset();
    do_reset();
    imem_ready = 1;
    repeat (2) step();
    flush_d = 1; stall_d = 1;
    step();
    flush_d = 0; stall_d = 0;
    checks++; if (valid_d !== 1'b0 || instr_d !== 32'h0 || pcplus4_d !== 32'h0) begin
      errors++; $display("FAIL flush_over_stall got v %b instr %h pc4 %h want 0 0 0", valid_d, instr_d, pcplus4_d); end
    pcsrc_m = 1; pcbranch_m = 32'hFFFF_FFFC;
    step();
    pcsrc_m = 0;
    step();
    checks++; if (imem_addr !== 32'h0 || pcplus4_d !== 32'h0 || instr_d !== 32'hFC || valid_d !== 1'b1) begin
      errors++; $display("FAIL wrap got pc %h pc4 %h instr %h v %b want 0 0 fc 1", imem_addr, pcplus4_d, instr_d, valid_d); end
    imem_ready = 0;
    step();
    #3 reset_n = 0;
    #1;
    checks++; if (imem_addr !== 32'h0 || valid_d !== 1'b0 || fetch_count !== 32'h0 || imem_req !== 1'b0) begin
      errors++; $display("FAIL async_reset got pc %h v %b cnt %0d req %b want 0 0 0 0", imem_addr, valid_d, fetch_count, imem_req); end
    #2 reset_n = 1;
    model_reset();
  endtask

  task automatic test_random();
    int bad = 0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      stall_f    = ($urandom_range(0, 3) == 0);
      stall_d    = ($urandom_range(0, 4) == 0);
      flush_d    = ($urandom_range(0, 9) == 0);
      pcsrc_m    = ($urandom_range(0, 11) == 0);
      pcbranch_m = $urandom & 32'hFFFF_FFFC;
      jump_d     = ($urandom_range(0, 5) == 0);
      imem_ready = ($urandom_range(0, 3) != 0);
      step();
      checks++;
      if (imem_addr !== m_pc || instr_d !== m_instr || pcplus4_d !== m_pp4 || valid_d !== m_valid ||
          fetch_count !== m_cnt || op_d !== m_instr[31:26] || funct_d !== m_instr[5:0] ||
          imem_req !== (m_run && !stall_f)) begin
        errors++; bad++;
        if (bad <= 5)
          $display("FAIL random_%0d got pc %h instr %h pc4 %h v %b cnt %0d want %h %h %h %b %0d",
                   i, imem_addr, instr_d, pcplus4_d, valid_d, fetch_count, m_pc, m_instr, m_pp4, m_valid, m_cnt);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_seq();
    test_wait();
    test_jump();
    test_branch();
    test_priority_wrap_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish within 200000 time units");
    $fatal(1);
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the pipelined MIPS core.
- Owns the PC and issues addresses to instruction memory, which may take several cycles to answer.
- Delivers op/funct/instruction to the decode-stage controller and takes back its redirect outputs: taken branch from M, jump from D.
- Hazard unit drives stall/flush.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
CNT_W, 32, width of retired-fetch counter

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
stall_f  in  1  hold PC (hazard unit)
stall_d  in  1  hold IF/ID register (hazard unit)
flush_d  in  1  load bubble into IF/ID (hazard unit)
pcsrc_m  in  1  taken branch resolved in M (BranchM & zero)
pcbranch_m  in  32  branch target from M
jump_d  in  1  decoded J in D (controller jump output)
imem_addr  out  32  instruction memory address (= PC)
imem_req  out  1  fetch request
imem_rdata  in  32  instruction word
imem_ready  in  1  imem_rdata valid for imem_addr this cycle
instr_d  out  32  IF/ID instruction
op_d  out  6  instr_d[31:26], to controller op
funct_d  out  6  instr_d[5:0], to controller funct
pcplus4_d  out  32  IF/ID PC+4
valid_d  out  1  IF/ID holds a real instruction
fetch_count  out  CNT_W  instructions accepted into IF/ID

Behaviour:
- Reset (async, reset_n=0): PC=RESET_PC; instr_d=0; pcplus4_d=0; valid_d=0; fetch_count=0.
- Reset release: imem_req=1 on the first clock.
- imem_addr = PC, combinational.
- imem_req = reset_n deasserted-synchronised and not stall_f.
- Instruction memory is word-aligned; PC[1:0] is always 00.
- Jump target, computed from IF/ID: jta = {pcplus4_d[31:28], instr_d[25:0], 2'b00}.
- Effective jump: jump_eff = jump_d & valid_d & ~stall_d.
- Next-PC priority, evaluated each rising edge:
  1. pcsrc_m=1 -> PC <= pcbranch_m. Overrides stall_f and imem_ready; the in-flight fetch is abandoned.
  2. else jump_eff=1 -> PC <= jta. Overrides stall_f.
  3. else stall_f=1 or imem_ready=0 -> PC holds.
  4. else PC <= PC+4, modulo 2^32 (wraps 32'hFFFF_FFFC -> 0).
- IF/ID update, priority order:
  1. flush_d | pcsrc_m | jump_eff -> bubble: instr_d=0, pcplus4_d=0, valid_d=0. Flush wins over stall_d.
  2. else stall_d=1 -> hold all IF/ID fields.
  3. else stall_f=1 or imem_ready=0 -> bubble.
  4. else instr_d <= imem_rdata; pcplus4_d <= PC+4; valid_d <= 1; fetch_count += 1 (wraps).
- Jump has exactly one delay slot fetched and discarded: the fall-through instruction becomes a bubble, and the target enters D one cycle after jump_eff (if imem_ready).
- Taken branch: the instruction in F is discarded and IF/ID becomes a bubble. The hazard unit is responsible for flushing E.
- A jump in D during pcsrc_m: the branch wins, and the jump is squashed with the bubble.
- Bubble is all-zero (op 000000, funct 000000). valid_d=0 marks it; downstream must gate writes on valid.
- imem_rdata is sampled only on an edge where imem_ready=1 and no redirect is taken.
- Ready pulses in other cycles are ignored.
- Reset asserted mid-fetch: all state returns to reset values immediately, and the pending memory response is ignored.

Test Plan:
- Sequential fetch: reset, imem_ready=1, memory returns addr+32'h100 as data. Required:
  - instr_d sequence 0x100, 0x104, 0x108 at pcplus4_d 4, 8, 12.
  - valid_d=1 from cycle 2.
  - fetch_count=3 after 3 accepts.
- Wait states: imem_ready low 2 cycles at PC=8. Required:
  - PC holds at 8.
  - valid_d=0 for 2 cycles.
  - instr at 8 delivered once on the ready cycle.
  - fetch_count not incremented during waits.
- Jump: instr_d=0x0800_0040 (J), pcplus4_d=0x14, jump_d=1. Required:
  - next PC=0x100.
  - IF/ID bubble.
  - next valid instr_d from 0x100.
  - same stimulus with stall_d=1 -> no redirect, IF/ID held.
- Taken branch with stall_f=1 and imem_ready=0: pcsrc_m=1, pcbranch_m=0x200. Required:
  - PC=0x200 next cycle.
  - instr_d=0, valid_d=0.
- Simultaneous pcsrc_m=1 (target 0x300) and jump_d=1 (jta 0x400) -> PC=0x300.
- Priority, wrap and reset:
  - flush_d+stall_d together -> bubble.
  - PC=0xFFFF_FFFC advances to 0.
  - reset_n pulsed low mid-wait -> PC=RESET_PC, valid_d=0, fetch_count=0 without a clock edge.
